// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch sequencer: one outstanding imem request, 1-entry decode buffer.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR.
module pc_fetch_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [XLEN-1:0] imem_resp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] ipc_q;
    logic [XLEN-1:0] ipc_d;
    logic            kill_q;
    logic            kill_d;
    logic            iv_q;
    logic            iv_d;
    logic            mis_q;
    logic            mis_d;
    logic            accept;
    logic            redirect;
    logic            bad_align;
    logic [XLEN-1:0] redir_pc;

    assign accept   = (state == S_REQ) && imem_req_ready_i;
    assign redirect = redirect_valid_i && (state != S_BOOT);

`ifdef PC_MISALIGN_TRAP_EN
    assign bad_align = (redirect_target_i[1:0] != 2'b00);
    assign redir_pc  = bad_align ? TRAP_VECTOR
                                 : {redirect_target_i[XLEN-1:2], 2'b00};
`else
    logic unused_cfg;
    assign unused_cfg = ^{TRAP_VECTOR, redirect_target_i[1:0]};
    assign bad_align  = 1'b0;
    assign redir_pc   = {redirect_target_i[XLEN-1:2], 2'b00};
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_d;
        end
    end

    // Next state and datapath updates; a redirect overrides the normal flow
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        kill_d  = kill_q;
        iv_d    = iv_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = 1'b0;

        unique case (state)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d = imem_resp_data_i;
                        ipc_d   = pc_q;
                        iv_d    = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready_i) begin
                    iv_d    = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (redirect) begin
            pc_d  = redir_pc;
            iv_d  = 1'b0;
            mis_d = bad_align;
            if ((state == S_WAIT) && imem_resp_valid_i) begin
                // Response lands with the redirect: drop it, nothing left in flight
                instr_d = instr_q;
                ipc_d   = ipc_q;
                kill_d  = 1'b0;
                state_d = S_REQ;
            end else if ((state == S_WAIT) || accept) begin
                // Request in flight: drain its response before refetching
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            kill_q  <= 1'b0;
            iv_q    <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            iv_q    <= iv_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req_valid_o = (state == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign pc_o             = pc_q;
    assign instr_valid_o    = iv_q;
    assign instr_o          = instr_q;
    assign instr_pc_o       = ipc_q;
    assign misalign_o       = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a latency-programmable imem model.
// Build with +define+PC_MISALIGN_TRAP_EN to check the trap variant.
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b1;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    logic        t_zero = 1'b0;
    logic        t_one = 1'b1;
    logic [31:0] t_zero32 = '0;
    logic [31:0] t_word = 32'hCAFE_F00D;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [31:0] w_pc;
    logic        w_misalign;

    int          vectors = 0;
    int          miscompares = 0;
    int          accepts = 0;
    int          cnt = 0;
    int          lat = 1;
    logic [31:0] paddr = '0;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] EXP5 = 32'h0000_0100;
    localparam logic [31:0] EXP_MIS = 32'd1;
`else
    localparam logic [31:0] EXP5 = 32'h0000_0200;
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    always #5 CLK = ~CLK;

    pc_fetch_sequencer dut (
        .CLK               (CLK),
        .reset             (reset),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .instr_valid_o     (instr_valid_o),
        .instr_ready_i     (instr_ready_i),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .pc_o              (pc_o),
        .misalign_o        (misalign_o)
    );

    pc_fetch_sequencer #(
        .RESET_VECTOR (32'hFFFF_FFFC)
    ) dut_wrap (
        .CLK               (CLK),
        .reset             (reset),
        .redirect_valid_i  (t_zero),
        .redirect_target_i (t_zero32),
        .imem_req_valid_o  (w_req_valid),
        .imem_req_ready_i  (t_one),
        .imem_req_addr_o   (w_req_addr),
        .imem_resp_valid_i (t_one),
        .imem_resp_data_i  (t_word),
        .instr_valid_o     (w_instr_valid),
        .instr_ready_i     (t_one),
        .instr_o           (w_instr),
        .instr_pc_o        (w_instr_pc),
        .pc_o              (w_pc),
        .misalign_o        (w_misalign)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // imem model: response 'lat' cycles after each accepted request
    always @(negedge CLK) begin
        imem_resp_valid_i = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_resp_valid_i = 1'b1;
                imem_resp_data_i  = word_at(paddr);
            end
        end
        if (imem_req_valid_o === 1'b1 && imem_req_ready_i && !reset) begin
            cnt     = lat;
            paddr   = imem_req_addr_o;
            accepts = accepts + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] exp);
        int n = 0;
        while (!(imem_req_valid_o === 1'b1 && imem_req_ready_i) && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(n < 20), 32'd1);
        chk("req_addr", imem_req_addr_o, exp);
    endtask

    task automatic wait_instr(input logic [31:0] exp);
        int n = 0;
        while (instr_valid_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("instr_seen", 32'(n < 20), 32'd1);
        chk("instr_pc", instr_pc_o, exp);
        chk("instr_word", instr_o, word_at(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and the first fetches, cycle by cycle
        step();
        step();
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        chk("rst_misalign", misalign_o, 0);
        chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        reset = 1'b0;
        step();
        chk("boot_req_valid", imem_req_valid_o, 1);
        chk("boot_req_addr", imem_req_addr_o, 32'h0);
        chk("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
        step();
        chk("wait_req_valid", imem_req_valid_o, 0);
        step();
        chk("hold_valid", instr_valid_o, 1);
        chk("hold_pc0", instr_pc_o, 32'h0);
        chk("hold_word0", instr_o, word_at(32'h0));
        chk("pc_after0", pc_o, 32'h4);
        chk("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", w_instr, 32'hCAFE_F00D);
        chk("wrap_pc", w_pc, 32'h0);
        step();
        chk("req4_valid", imem_req_valid_o, 1);
        chk("req4_addr", imem_req_addr_o, 32'h4);
        chk("wrap_req0", w_req_addr, 32'h0);
        chk("wrap_req0_valid", w_req_valid, 1);
        wait_instr(32'h4);
        wait_req(32'h8);
        wait_instr(32'h8);

        // imem not ready: request held stable
        imem_req_ready_i = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", imem_req_valid_o, 1);
            chk("stall_addr", imem_req_addr_o, 32'hC);
            step();
        end
        imem_req_ready_i = 1'b1;
        wait_req(32'hC);
        wait_instr(32'hC);
        chk("single_accept", accepts, 4);

        // decode stall: instruction held, no new request
        wait_req(32'h10);
        instr_ready_i = 1'b0;
        wait_instr(32'h10);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dstall_valid", instr_valid_o, 1);
            chk("dstall_word", instr_o, word_at(32'h10));
            chk("dstall_pc", instr_pc_o, 32'h10);
            chk("dstall_noreq", imem_req_valid_o, 0);
        end
        chk("dstall_accepts", accepts, 5);
        instr_ready_i = 1'b1;
        step();
        chk("consume_req", imem_req_valid_o, 1);
        chk("consume_addr", imem_req_addr_o, 32'h14);

        // redirect while waiting: in-flight word discarded
        lat = 3;
        wait_req(32'h14);
        step();
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h200;
        step();
        redirect_valid_i  = 1'b0;
        lat = 1;
        chk("redir_pc", pc_o, 32'h200);
        chk("redir_noreq", imem_req_valid_o, 0);
        chk("redir_iv", instr_valid_o, 0);
        wait_req(32'h200);
        wait_instr(32'h200);
        wait_req(32'h204);
        wait_instr(32'h204);

        // redirect in HOLD squashes even with decode ready
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h300;
        step();
        redirect_valid_i  = 1'b0;
        chk("squash_iv", instr_valid_o, 0);
        chk("squash_req", imem_req_valid_o, 1);
        chk("squash_addr", imem_req_addr_o, 32'h300);

        // misaligned redirect in REQ with accept
        redirect_valid_i  = 1'b1;
        redirect_target_i = 32'h203;
        step();
        redirect_valid_i  = 1'b0;
        chk("mis_pc", pc_o, EXP5);
        chk("mis_pulse", misalign_o, EXP_MIS);
        chk("mis_wait", imem_req_valid_o, 0);
        step();
        chk("mis_pulse_end", misalign_o, 0);
        wait_req(EXP5);
        wait_instr(EXP5);

        // reset during WAIT: restart at reset vector, late response ignored
        step();
        lat = 3;
        step();
        chk("pre_rst_wait", imem_req_valid_o, 0);
        reset = 1'b1;
        step();
        step();
        chk("mid_rst_req", imem_req_valid_o, 0);
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_iv", instr_valid_o, 0);
        chk("mid_rst_instr", instr_o, 32'h0);
        chk("mid_rst_ipc", instr_pc_o, 32'h0);
        reset = 1'b0;
        lat = 1;
        wait_req(32'h0);
        wait_instr(32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
